vga_frame_reader: RTL



---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_timing.sv | 43 ++++
 rtl/vga_frame_reader.sv | 95 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, frame-buffer geometry and pixel types for the VGA reader.
// No logic of its own; LUMA_GRAY_EN (in vga_frame_reader) selects the colour mapping.
package vga_pkg;
  localparam int H_VIS    = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_VIS    = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int SCALE_SH = 2;

  localparam int FB_W = 160;
  localparam int FB_H = 120;

  localparam int CNT_W = 10;

  typedef logic [14:0] fb_addr_t;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } sync_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Blanked, both syncs deasserted (syncs are active low).
  localparam sync_t SYNC_IDLE = sync_t'(3'b011);

  function automatic rgb_t rgb565_to_rgb888(input logic [15:0] d);
    rgb_t p;
    p.r = {d[15:11], d[15:13]};
    p.g = {d[10:5],  d[10:9]};
    p.b = {d[4:0],   d[4:2]};
    return p;
  endfunction
endpackage

// File: rtl/vga_timing.sv
// Free-running hcnt/vcnt raster counters with combinational visible/hsync/vsync flags.
// Flags are combinational from the counters (zero latency); free-running, no backpressure.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             vis0,
  output logic             hs0,
  output logic             vs0
);
  localparam int HT       = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int VS_START = V_VIS + V_FP;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == CNT_W'(HT - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == CNT_W'(VT - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  assign vis0 = (hcnt < CNT_W'(H_VIS)) && (vcnt < CNT_W'(V_VIS));
  assign hs0  = !((hcnt >= CNT_W'(HS_START)) && (hcnt < CNT_W'(HS_START + H_SYNC)));
  assign vs0  = !((vcnt >= CNT_W'(VS_START)) && (vcnt < CNT_W'(VS_START + V_SYNC)));
endmodule

// File: rtl/vga_frame_reader.sv
// Reads the 160x120 frame buffer, 4x upscales to 640x480 VGA; counter-to-pin latency 2 cycles.
// Free-running display, no backpressure; `define LUMA_GRAY_EN for grey output from rddata[15:8].
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int H_VIS    = vga_pkg::H_VIS,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_VIS    = vga_pkg::V_VIS,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int SCALE_SH = vga_pkg::SCALE_SH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] rddata,
  output fb_addr_t    rdaddr,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vblank
);
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             vis0;
  logic             hs0;
  logic             vs0;
  logic [7:0]       fx;
  logic [6:0]       fy;
  sync_t            sync1;
  rgb_t             pix;
  rgb_t             colour;

  vga_timing #(
    .H_VIS (H_VIS),  .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk     (clk),
    .reset_n (reset_n),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .vis0    (vis0),
    .hs0     (hs0),
    .vs0     (vs0)
  );

  // Dropping the low SCALE_SH bits repeats each source pixel/line 4 times.
  assign fx     = 8'(hcnt >> SCALE_SH);
  assign fy     = 7'(vcnt >> SCALE_SH);
  assign rdaddr = vis0 ? {fx, fy} : '0;

  // Stage 1: sync/blank wait alongside the registered RAM read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= SYNC_IDLE;
    end else begin
      sync1 <= '{vis: vis0, hs: hs0, vs: vs0};
    end
  end

  always_comb begin
    pix = '0;
`ifdef LUMA_GRAY_EN
    pix = '{r: rddata[15:8], g: rddata[15:8], b: rddata[15:8]};
`else
    pix = rgb565_to_rgb888(rddata);
`endif
  end

  // Stage 2: output registers; rddata is only meaningful while vis1 is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      colour      <= '0;
      vblank      <= 1'b0;
    end else begin
      vga_hs      <= sync1.hs;
      vga_vs      <= sync1.vs;
      vga_blank_n <= sync1.vis;
      colour      <= sync1.vis ? pix : '0;
      vblank      <= (vcnt >= CNT_W'(V_VIS));
    end
  end

  assign vga_r = colour.r;
  assign vga_g = colour.g;
  assign vga_b = colour.b;
endmodule
